// File: rtl/dfr_pkg.sv
// Shared types for the DFR run sequencer: FSM states, run phases and the
// phase-skipping helper.
package dfr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STEP,
    S_MAC_WAIT,
    S_WRITE,
    S_NEXT,
    S_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    PHASE_IDLE  = 2'd0,
    PHASE_INIT  = 2'd1,
    PHASE_TRAIN = 2'd2,
    PHASE_TEST  = 2'd3
  } phase_t;

  // First phase after cur whose sample count is non-zero; nz = {test, train, init}.
  // PHASE_IDLE means no phase remains.
  function automatic phase_t next_phase(input phase_t cur, input logic [2:0] nz);
    phase_t np;
    np = PHASE_IDLE;
    if (cur == PHASE_IDLE && nz[0]) np = PHASE_INIT;
    else if ((cur == PHASE_IDLE || cur == PHASE_INIT) && nz[1]) np = PHASE_TRAIN;
    else if (cur != PHASE_TEST && nz[2]) np = PHASE_TEST;
    return np;
  endfunction

endpackage

// File: rtl/dfr_step_counter.sv
// Loadable down-counter with zero flag; used for reservoir steps and for
// samples remaining in the current phase.
module dfr_step_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dfr_phase_sequencer.sv
// Sequences one DFR run (init -> train -> test) for dfr_core_top.
// Optional macro DFR_SEQ_ABORT_EN adds an abort input.
module dfr_phase_sequencer
  import dfr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_init_samples,
  input  logic [CNT_WIDTH-1:0]  num_train_samples,
  input  logic [CNT_WIDTH-1:0]  num_test_samples,
  input  logic [CNT_WIDTH-1:0]  num_steps_per_sample,
  output logic                  in_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] in_mem_addr,
  output logic                  sample_load,
  output logic                  res_step,
  output logic                  hist_wr_en,
  output logic [ADDR_WIDTH-1:0] hist_addr,
  output logic                  mac_start,
  input  logic                  mac_done,
`ifdef DFR_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  out_wr_en,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [1:0]            phase,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  seq_state_t state_q, state_d;
  phase_t     phase_q, phase_d, next_ph;
  logic       cfg_err_q, cfg_err_d, mac_start_q, mac_start_d;
  logic [ADDR_WIDTH-1:0] in_addr_q, in_addr_d, hist_addr_q, hist_addr_d, out_addr_q, out_addr_d;
  logic [CNT_WIDTH-1:0]  ni_q, ni_d, nt_q, nt_d, ns_q, ns_d, n_q, n_d;
  logic [CNT_WIDTH-1:0]  samp_val;
  logic       samp_load, samp_dec, samp_zero, step_load, step_dec, step_zero;
  logic [2:0] nz_in, nz_q;

  function automatic logic [CNT_WIDTH-1:0] pick(input phase_t p, input logic [CNT_WIDTH-1:0] a,
                                                input logic [CNT_WIDTH-1:0] b, input logic [CNT_WIDTH-1:0] c);
    case (p)
      PHASE_INIT:  return a;
      PHASE_TRAIN: return b;
      default:     return c;
    endcase
  endfunction

  assign nz_in = {num_test_samples != '0, num_train_samples != '0, num_init_samples != '0};
  assign nz_q  = {ns_q != '0, nt_q != '0, ni_q != '0};
  assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cfg_err_d   = 1'b0;
    in_addr_d   = in_addr_q;
    hist_addr_d = hist_addr_q;
    out_addr_d  = out_addr_q;
    ni_d        = ni_q;
    nt_d        = nt_q;
    ns_d        = ns_q;
    n_d         = n_q;
    samp_load   = 1'b0;
    samp_val    = '0;
    samp_dec    = 1'b0;
    step_load   = 1'b0;
    step_dec    = 1'b0;
    next_ph     = PHASE_IDLE;
    case (state_q)
      S_IDLE: if (start) begin
        if (num_steps_per_sample == '0 || nz_in == 3'b000) begin
          cfg_err_d = 1'b1;
        end else begin
          state_d     = S_FETCH;
          next_ph     = next_phase(PHASE_IDLE, nz_in);
          phase_d     = next_ph;
          ni_d        = num_init_samples;
          nt_d        = num_train_samples;
          ns_d        = num_test_samples;
          n_d         = num_steps_per_sample;
          samp_load   = 1'b1;
          samp_val    = pick(next_ph, num_init_samples, num_train_samples, num_test_samples) - CNT_WIDTH'(1);
          in_addr_d   = '0;
          hist_addr_d = '0;
          out_addr_d  = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        step_load = 1'b1;
        state_d   = S_STEP;
      end
      S_STEP: begin
        step_dec = 1'b1;
        if (phase_q != PHASE_INIT) hist_addr_d = hist_addr_q + ADDR_WIDTH'(1);
        if (step_zero) state_d = (phase_q == PHASE_TEST) ? S_MAC_WAIT : S_NEXT;
      end
      S_MAC_WAIT: if (mac_done) state_d = S_WRITE;
      S_WRITE: begin
        out_addr_d = out_addr_q + ADDR_WIDTH'(1);
        state_d    = S_NEXT;
      end
      S_NEXT: begin
        in_addr_d = in_addr_q + ADDR_WIDTH'(1);
        state_d   = S_FETCH;
        if (!samp_zero) begin
          samp_dec = 1'b1;
        end else begin
          // Last sample of this phase: jump over empty phases or finish.
          next_ph = next_phase(phase_q, nz_q);
          if (next_ph == PHASE_IDLE) begin
            state_d = S_DONE;
            phase_d = PHASE_IDLE;
          end else begin
            phase_d   = next_ph;
            samp_load = 1'b1;
            samp_val  = pick(next_ph, ni_q, nt_q, ns_q) - CNT_WIDTH'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef DFR_SEQ_ABORT_EN
    if (abort && busy) begin
      state_d = S_IDLE;
      phase_d = PHASE_IDLE;
    end
`else
`endif
    mac_start_d = (state_q == S_STEP) && (state_d == S_MAC_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= PHASE_IDLE;
      cfg_err_q   <= 1'b0;
      mac_start_q <= 1'b0;
      in_addr_q   <= '0;
      hist_addr_q <= '0;
      out_addr_q  <= '0;
      ni_q        <= '0;
      nt_q        <= '0;
      ns_q        <= '0;
      n_q         <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cfg_err_q   <= cfg_err_d;
      mac_start_q <= mac_start_d;
      in_addr_q   <= in_addr_d;
      hist_addr_q <= hist_addr_d;
      out_addr_q  <= out_addr_d;
      ni_q        <= ni_d;
      nt_q        <= nt_d;
      ns_q        <= ns_d;
      n_q         <= n_d;
    end
  end

  dfr_step_counter #(.WIDTH(CNT_WIDTH)) u_step_cnt (
    .clk(clk), .rst(rst), .load(step_load), .load_val(n_q - CNT_WIDTH'(1)),
    .dec(step_dec), .zero(step_zero)
  );

  dfr_step_counter #(.WIDTH(CNT_WIDTH)) u_samp_cnt (
    .clk(clk), .rst(rst), .load(samp_load), .load_val(samp_val),
    .dec(samp_dec), .zero(samp_zero)
  );

`ifdef DFR_SEQ_ABORT_EN
  // Abort returns straight to IDLE, so its done pulse comes from a flop.
  logic abort_done_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) abort_done_q <= 1'b0;
    else     abort_done_q <= abort && busy;
  end
  assign done = (state_q == S_DONE) || abort_done_q;
`else
  assign done = (state_q == S_DONE);
`endif

  assign in_mem_rd_en = (state_q == S_FETCH);
  assign in_mem_addr  = in_addr_q;
  assign sample_load  = (state_q == S_LOAD);
  assign res_step     = (state_q == S_STEP);
  assign hist_wr_en   = (state_q == S_STEP) && (phase_q != PHASE_INIT);
  assign hist_addr    = hist_addr_q;
  assign mac_start    = mac_start_q;
  assign out_wr_en    = (state_q == S_WRITE);
  assign out_addr     = out_addr_q;
  assign phase        = phase_q;
  assign cfg_err      = cfg_err_q;

endmodule
